// File: rtl/tone_seq_pkg.sv
// Package: tone_seq_pkg
// Shared definitions for the tone sequencer: player state encoding, tempo helper and the
// field layout of a note-table word.
//   note word = {half_period[PERIOD_W-1:0], duration[DUR_W-1:0]}
package tone_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StPlay,
        StDone
    } state_e;

    // Duration field always sits in the low bits of a note word.
    localparam int unsigned DUR_LSB = 0;

    // UNIT_CYCLES: clock cycles per duration unit for a given clock and tempo.
    function automatic int unsigned unit_cycles(int unsigned clk_hz, int unsigned tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // Half-period field starts directly above the duration field.
    function automatic int unsigned period_lsb(int unsigned dur_w);
        return DUR_LSB + dur_w;
    endfunction

endpackage

// File: rtl/tone_sequencer_if.sv
// Interface: tone_sequencer_if
// Bundles the player control inputs, the song ROM port and the audio/status outputs.
//   start, stop, playSound, loop_en : player control (controller -> sequencer)
//   rom_addr / rom_data             : synchronous ROM port, data valid 1 cycle after address
//   note_idx, audioOut, aud_sd      : current note, square wave, amplifier enable
//   busy, done                      : status
// Modports: master = controller + ROM side, slave = the sequencer.
interface tone_sequencer_if #(
    parameter int unsigned PERIOD_W = 20,
    parameter int unsigned DUR_W    = 5,
    parameter int unsigned ADDR_W   = 6
);
    logic                      start;
    logic                      stop;
    logic                      playSound;
    logic                      loop_en;
    logic [ADDR_W-1:0]         rom_addr;
    logic [PERIOD_W+DUR_W-1:0] rom_data;
    logic [ADDR_W-1:0]         note_idx;
    logic                      audioOut;
    logic                      aud_sd;
    logic                      busy;
    logic                      done;

    modport master (
        output start, stop, playSound, loop_en, rom_data,
        input  rom_addr, note_idx, audioOut, aud_sd, busy, done
    );

    modport slave (
        input  start, stop, playSound, loop_en, rom_data,
        output rom_addr, note_idx, audioOut, aud_sd, busy, done
    );
endinterface

// File: rtl/tone_gen.sv
// Module: tone_gen
// Half-period divider producing a square wave.
//   clock, reset : system clock, async active-high reset
//   enable_i     : count this cycle; when low the phase is held and the output is muted
//   clear_i      : restart the divider with the output low (wins over enable_i)
//   rest_i       : silent note, no counting and output low
//   period_i     : half period in clock cycles
//   wave_o       : square wave
module tone_gen #(
    parameter int unsigned PERIOD_W = 20
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable_i,
    input  logic                clear_i,
    input  logic                rest_i,
    input  logic [PERIOD_W-1:0] period_i,
    output logic                wave_o
);
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (clear_i) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (enable_i && !rest_i) begin
            if (cnt_q == period_i - 1'b1) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    // Muting is combinational so a pause silences the pin in the same cycle
    // while the held phase keeps the waveform continuous on resume.
    assign wave_o = phase_q & enable_i & ~rest_i;
endmodule

// File: rtl/tone_sequencer.sv
// Module: tone_sequencer
// Single-voice song player: walks a note table in an external synchronous ROM and drives a
// square-wave audio pin with per-note pitch and duration. Supports start/stop, pause/resume,
// one-shot or loop playback and a zero-duration end-of-song marker.
//   clock, reset : system clock, async active-high reset
//   bus (slave)  : control inputs, ROM port, audio and status outputs (see tone_sequencer_if)
module tone_sequencer
    import tone_seq_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned TICK_HZ  = 8,
    parameter int unsigned PERIOD_W = 20,
    parameter int unsigned DUR_W    = 5,
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned SONG_LEN = 41
) (
    input logic             clock,
    input logic             reset,
    tone_sequencer_if.slave bus
);
    localparam int unsigned UnitCycles   = unit_cycles(CLK_HZ, TICK_HZ);
    localparam int unsigned PeriodLsb    = period_lsb(DUR_W);
    localparam logic [63:0] MaxDurCycles = ((64'd1 << DUR_W) - 64'd1) * 64'(UnitCycles);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(SONG_LEN - 1);

    // The longest note must fit the 32-bit duration counter.
    if (UnitCycles == 0 || MaxDurCycles >= 64'h1_0000_0000) begin : g_bad_tempo
        $error("tone_sequencer: longest note does not fit a 32-bit duration counter");
    end
    if (SONG_LEN == 0 || SONG_LEN > (1 << ADDR_W)) begin : g_bad_song_len
        $error("tone_sequencer: SONG_LEN does not fit the ROM address range");
    end

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [DUR_W-1:0]    dur_q, dur_d;
    logic [31:0]         dur_cnt_q, dur_cnt_d;
    logic [31:0]         dur_cycles;
    logic [PERIOD_W-1:0] rom_period;
    logic [DUR_W-1:0]    rom_dur;
    logic                tone_en, tone_clear, tone_rest, tone_wave;
    logic                busy_w;

    assign rom_dur    = bus.rom_data[DUR_LSB +: DUR_W];
    assign rom_period = bus.rom_data[PeriodLsb +: PERIOD_W];
    assign dur_cycles = 32'(dur_q) * 32'(UnitCycles);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        idx_d      = idx_q;
        period_d   = period_q;
        dur_d      = dur_q;
        dur_cnt_d  = dur_cnt_q;
        // The divider only runs in PLAY; everywhere else it sits cleared with the pin low.
        tone_clear = (state_q != StPlay);

        unique case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    state_d = StFetch;
                    addr_d  = '0;
                end
            end
            StFetch: state_d = StLoad;
            StLoad: begin
                period_d  = rom_period;
                dur_d     = rom_dur;
                idx_d     = addr_q;
                dur_cnt_d = '0;
                if (rom_dur == '0) begin
                    if (bus.loop_en) begin
                        state_d = StFetch;
                        addr_d  = '0;
                    end else begin
                        state_d = StDone;
                    end
                end else begin
                    state_d = StPlay;
                end
            end
            StPlay: begin
                if (bus.playSound) begin
                    if (dur_cnt_q == dur_cycles - 32'd1) begin
                        tone_clear = 1'b1;
                        dur_cnt_d  = '0;
                        if (addr_q == LastAddr) begin
                            if (bus.loop_en) begin
                                state_d = StFetch;
                                addr_d  = '0;
                            end else begin
                                state_d = StDone;
                            end
                        end else begin
                            state_d = StFetch;
                            addr_d  = addr_q + 1'b1;
                        end
                    end else begin
                        dur_cnt_d = dur_cnt_q + 32'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // stop overrides everything, including a simultaneous start.
        if (bus.stop) begin
            state_d    = StIdle;
            addr_d     = '0;
            dur_cnt_d  = '0;
            tone_clear = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            idx_q     <= '0;
            period_q  <= '0;
            dur_q     <= '0;
            dur_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            idx_q     <= idx_d;
            period_q  <= period_d;
            dur_q     <= dur_d;
            dur_cnt_q <= dur_cnt_d;
        end
    end

    assign tone_en   = (state_q == StPlay) && bus.playSound;
    assign tone_rest = (period_q == '0);

    tone_gen #(
        .PERIOD_W(PERIOD_W)
    ) u_tone_gen (
        .clock   (clock),
        .reset   (reset),
        .enable_i(tone_en),
        .clear_i (tone_clear),
        .rest_i  (tone_rest),
        .period_i(period_q),
        .wave_o  (tone_wave)
    );

    assign busy_w       = (state_q == StFetch) || (state_q == StLoad) || (state_q == StPlay);
    assign bus.busy     = busy_w;
    assign bus.aud_sd   = busy_w;
    assign bus.done     = (state_q == StDone);
    assign bus.rom_addr = addr_q;
    assign bus.note_idx = idx_q;
    assign bus.audioOut = tone_wave;
endmodule

// File: tb/tb_tone_sequencer.sv
// Testbench for tone_sequencer: small clock (UNIT_CYCLES = 10), 4-entry song ROM modelled
// here, per-cycle comparison against a note-level reference model.
module tb_tone_sequencer;
    localparam int unsigned PERIOD_W = 20;
    localparam int unsigned DUR_W    = 5;
    localparam int unsigned ADDR_W   = 6;
    localparam int          SONG_LEN = 4;
    localparam int          UNIT     = 10;
    localparam int          MAXN     = 256;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    tone_sequencer_if #(
        .PERIOD_W(PERIOD_W),
        .DUR_W   (DUR_W),
        .ADDR_W  (ADDR_W)
    ) bus ();

    tone_sequencer #(
        .CLK_HZ  (80),
        .TICK_HZ (8),
        .PERIOD_W(PERIOD_W),
        .DUR_W   (DUR_W),
        .ADDR_W  (ADDR_W),
        .SONG_LEN(SONG_LEN)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    // Song table and synchronous ROM.
    int per_tab[SONG_LEN];
    int dur_tab[SONG_LEN];
    logic [PERIOD_W+DUR_W-1:0] rom_q = '0;

    always @(posedge clock) begin
        if (bus.rom_addr < ADDR_W'(SONG_LEN))
            rom_q <= {PERIOD_W'(per_tab[bus.rom_addr[1:0]]), DUR_W'(dur_tab[bus.rom_addr[1:0]])};
        else
            rom_q <= '0;
    end
    assign bus.rom_data = rom_q;

    // Per-cycle playSound schedule and traces; packed as {audio, busy, done, aud_sd, idx[5:0]}.
    bit                play[MAXN];
    logic [9:0]        exp_v[MAXN];
    logic [9:0]        mask_v[MAXN];
    logic [9:0]        obs_v[MAXN];
    logic [ADDR_W-1:0] obs_addr[MAXN];

    function automatic void put(int t, bit a, bit b, bit d, int idx);
        exp_v[t]  = {a, b, d, b, (idx < 0) ? 6'd0 : 6'(idx)};
        mask_v[t] = (idx < 0) ? 10'h3C0 : 10'h3FF;
    endfunction

    // Note-level model: t=0 is the first cycle after start is sampled. Each note costs a
    // 2-cycle silent gap, then dur*UNIT unpaused cycles; the wave level is (k/period)%2 where
    // k counts unpaused cycles of the note. Paused cycles are silent and do not advance k.
    function automatic void build_expect(int n, bit lp);
        int t   = 0;
        int idx = 0;
        bit fin = 0;
        while (t < n) begin
            if (fin) begin
                put(t, 0, 0, 1, -1);
                t++;
                continue;
            end
            for (int g = 0; g < 2 && t < n; g++) begin
                put(t, 0, 1, 0, -1);
                t++;
            end
            if (dur_tab[idx] == 0) begin
                if (lp) idx = 0;
                else    fin = 1;
                continue;
            end
            begin
                int k;
                int len;
                k   = 0;
                len = dur_tab[idx] * UNIT;
                while (k < len && t < n) begin
                    if (play[t]) begin
                        put(t, (per_tab[idx] != 0) && (((k / per_tab[idx]) % 2) == 1), 1, 0, idx);
                        k++;
                    end else begin
                        put(t, 0, 1, 0, idx);
                    end
                    t++;
                end
            end
            if (idx == SONG_LEN - 1) begin
                if (lp) idx = 0;
                else    fin = 1;
            end else begin
                idx++;
            end
        end
    endfunction

    // Stimulus helpers (all called at posedge+1).
    task automatic start_song();
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
    endtask

    task automatic capture(int n);
        for (int t = 0; t < n; t++) begin
            bus.playSound = play[t];
            @(negedge clock);
            obs_v[t]    = {bus.audioOut, bus.busy, bus.done, bus.aud_sd, bus.note_idx};
            obs_addr[t] = bus.rom_addr;
            @(posedge clock); #1;
        end
        bus.playSound = 1'b1;
    endtask

    task automatic go_idle();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic set_rom(int p0, int d0, int p1, int d1, int p2, int d2, int p3, int d3);
        per_tab[0] = p0; dur_tab[0] = d0;
        per_tab[1] = p1; dur_tab[1] = d1;
        per_tab[2] = p2; dur_tab[2] = d2;
        per_tab[3] = p3; dur_tab[3] = d3;
    endtask

    task automatic all_play();
        for (int t = 0; t < MAXN; t++) play[t] = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clock);
        for (int r = 0; r < 2; r++) begin
            checks++;
            if ({bus.rom_addr, bus.note_idx, bus.audioOut, bus.aud_sd, bus.busy, bus.done} !== '0) begin
                failures++;
                $display("FAIL reset_state phase=%0d got addr=%0d idx=%0d aud=%b sd=%b busy=%b done=%b required all 0",
                         r, bus.rom_addr, bus.note_idx, bus.audioOut, bus.aud_sd, bus.busy, bus.done);
            end
            @(posedge clock); #1;
            reset = 1'b0;
            @(negedge clock);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_one_shot();
        set_rom(3, 1, 0, 2, 5, 1, 2, 1);
        bus.loop_en = 1'b0;
        all_play();
        build_expect(66, 0);
        start_song();
        capture(66);
        for (int t = 0; t < 66; t++) begin
            checks++;
            if ((obs_v[t] & mask_v[t]) !== exp_v[t]) begin
                failures++;
                $display("FAIL one_shot t=%0d {aud,busy,done,sd,idx} got=%b required=%b",
                         t, obs_v[t] & mask_v[t], exp_v[t]);
            end
        end
    endtask

    task automatic test_loop();
        set_rom(3, 1, 0, 2, 5, 1, 2, 1);
        bus.loop_en = 1'b1;
        all_play();
        build_expect(120, 1);
        start_song();
        capture(120);
        for (int t = 0; t < 120; t++) begin
            checks++;
            if ((obs_v[t] & mask_v[t]) !== exp_v[t]) begin
                failures++;
                $display("FAIL loop t=%0d {aud,busy,done,sd,idx} got=%b required=%b",
                         t, obs_v[t] & mask_v[t], exp_v[t]);
            end
        end
        bus.loop_en = 1'b0;
    endtask

    task automatic test_end_marker();
        bit seen3;
        set_rom(3, 1, 0, 2, 4, 0, 2, 1);
        bus.loop_en = 1'b0;
        all_play();
        build_expect(50, 0);
        start_song();
        capture(50);
        seen3 = 1'b0;
        for (int t = 0; t < 50; t++) begin
            if (obs_addr[t] == ADDR_W'(3)) seen3 = 1'b1;
            checks++;
            if ((obs_v[t] & mask_v[t]) !== exp_v[t]) begin
                failures++;
                $display("FAIL end_marker t=%0d {aud,busy,done,sd,idx} got=%b required=%b",
                         t, obs_v[t] & mask_v[t], exp_v[t]);
            end
        end
        checks++;
        if (seen3 !== 1'b0) begin
            failures++;
            $display("FAIL end_marker_no_fetch3 got addr3_seen=%b required=0", seen3);
        end
    endtask

    task automatic test_pause();
        set_rom(3, 2, 2, 1, 0, 0, 0, 0);
        bus.loop_en = 1'b0;
        all_play();
        // PLAY starts at t=2; pause after 5 played cycles, for 7 cycles.
        for (int t = 7; t < 14; t++) play[t] = 1'b0;
        build_expect(60, 0);
        start_song();
        capture(60);
        for (int t = 0; t < 60; t++) begin
            checks++;
            if ((obs_v[t] & mask_v[t]) !== exp_v[t]) begin
                failures++;
                $display("FAIL pause t=%0d {aud,busy,done,sd,idx} got=%b required=%b",
                         t, obs_v[t] & mask_v[t], exp_v[t]);
            end
        end
        // Note 0 ends 15 cycles after resume (t=14), so FETCH of entry 1 is at t=29.
        checks++;
        if (obs_addr[28] !== ADDR_W'(0) || obs_addr[29] !== ADDR_W'(1)) begin
            failures++;
            $display("FAIL pause_note_end got addr[28]=%0d addr[29]=%0d required 0 and 1",
                     obs_addr[28], obs_addr[29]);
        end
        all_play();
    endtask

    task automatic test_stop_start();
        set_rom(3, 2, 2, 1, 1, 1, 4, 1);
        bus.loop_en = 1'b0;
        all_play();
        start_song();
        capture(8);
        bus.stop  = 1'b1;
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.stop  = 1'b0;
        bus.start = 1'b0;
        @(negedge clock);
        checks++;
        if ({bus.busy, bus.audioOut, bus.done, bus.aud_sd} !== 4'b0000 || bus.rom_addr !== '0) begin
            failures++;
            $display("FAIL stop_wins got busy=%b aud=%b done=%b sd=%b addr=%0d required all 0",
                     bus.busy, bus.audioOut, bus.done, bus.aud_sd, bus.rom_addr);
        end
        @(posedge clock); #1;
        build_expect(40, 0);
        start_song();
        capture(40);
        for (int t = 0; t < 40; t++) begin
            checks++;
            if ((obs_v[t] & mask_v[t]) !== exp_v[t]) begin
                failures++;
                $display("FAIL restart t=%0d {aud,busy,done,sd,idx} got=%b required=%b",
                         t, obs_v[t] & mask_v[t], exp_v[t]);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            bit lp;
            for (int e = 0; e < SONG_LEN; e++) begin
                per_tab[e] = int'($urandom_range(0, 6));
                dur_tab[e] = int'($urandom_range(0, 3));
            end
            lp          = 1'($urandom_range(0, 1));
            bus.loop_en = lp;
            for (int t = 0; t < MAXN; t++) play[t] = ($urandom_range(0, 3) != 0);
            build_expect(150, lp);
            start_song();
            capture(150);
            for (int t = 0; t < 150; t++) begin
                checks++;
                if ((obs_v[t] & mask_v[t]) !== exp_v[t]) begin
                    failures++;
                    $display("FAIL random it=%0d t=%0d {aud,busy,done,sd,idx} got=%b required=%b",
                             it, t, obs_v[t] & mask_v[t], exp_v[t]);
                end
            end
            go_idle();
        end
        bus.loop_en = 1'b0;
        all_play();
    endtask

    task automatic test_async_reset();
        set_rom(3, 2, 2, 1, 1, 1, 4, 1);
        bus.loop_en = 1'b0;
        all_play();
        start_song();
        capture(7);
        // t=7 is the 6th played cycle of note 0: wave high.
        #2;
        checks++;
        if ({bus.audioOut, bus.busy} !== 2'b11) begin
            failures++;
            $display("FAIL async_reset_pre got aud=%b busy=%b required 1 1", bus.audioOut, bus.busy);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.rom_addr, bus.note_idx, bus.audioOut, bus.aud_sd, bus.busy, bus.done} !== '0) begin
            failures++;
            $display("FAIL async_reset got addr=%0d idx=%0d aud=%b sd=%b busy=%b done=%b required all 0",
                     bus.rom_addr, bus.note_idx, bus.audioOut, bus.aud_sd, bus.busy, bus.done);
        end
        #1;
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.playSound = 1'b1;
        bus.loop_en   = 1'b0;
        set_rom(0, 0, 0, 0, 0, 0, 0, 0);
        all_play();
        #1;
        test_reset();
        test_one_shot();
        go_idle();
        test_loop();
        go_idle();
        test_end_marker();
        go_idle();
        test_pause();
        go_idle();
        test_stop_start();
        go_idle();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
